joystick_serial: RTL and testbench
==================================

Name: joystick_serial

Overview:
- Parametrised serial joystick reader for shift-register joystick adapters (74165-style chain), driving load/clock and sampling one data line.
- Generalises the fixed 2x6-bit reader: N channels, configurable bits per channel and reported width, and clock divider.
- Adds per-channel frame-agreement debounce, frame-valid and change strobes, and an enable with clean stop.
- Sits between board joystick pins and the core's input/keyboard matrix logic.

Parameters:
- NJOY, 2, number of joystick channels in the chain.
- NBITS, 8, bits shifted per channel.
- OUTW, 6, bits reported per channel (OUTW <= NBITS); low bits of each channel.
- DIV, 1, ce ticks per serial phase (load, clock-low, clock-high), >= 1.
- DEBOUNCE, 2, consecutive identical frames required before a channel output updates, >= 1.
- INVERT, 1, 1 = stored bit is ~joyD (active-low buttons), 0 = joyD.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; all sequencing advances only on ce.
- enable  in  1  1 = run frames continuously; 0 = finish current frame, then idle.
- joy  out  NJOY*OUTW  debounced state; channel c at [c*OUTW +: OUTW], 1 = pressed when INVERT=1.
- valid  out  1  one-clock pulse at each completed frame.
- changed  out  1  one-clock pulse, coincident with valid, when any joy bit changed value.
- joyS  out  1  constant 1 (adapter select).
- joyCk  out  1  shift clock to chain.
- joyLd  out  1  parallel load, active low.
- joyD  in  1  serial data from chain.

Behaviour:
- Reset (async, reset_n=0): joy=0, valid=0, changed=0, joyCk=0, joyLd=1, shift register and debounce state cleared, FSM=IDLE. Reset mid-frame discards the partial frame.
- FRAME = NJOY*NBITS. Phase timer counts DIV ce ticks per phase.
- FSM states:
  - IDLE: joyCk=0, joyLd=1. Go to LOAD on ce with enable=1.
  - LOAD: joyLd=0, joyCk=0 for DIV ticks, then LOW.
  - LOW: joyLd=1, joyCk=0 for DIV ticks, then HIGH.
  - HIGH: joyCk=1 for DIV ticks. On the last tick, shift in joyD (inverted if INVERT) and increment the bit counter. If FRAME bits are done go to DONE, else LOW.
  - DONE: one ce tick. Run debounce and update outputs. Go to LOAD if enable=1, else IDLE.
- Frame period: DIV*(1+2*FRAME)+1 ce ticks. Defaults give 34.
- Bit order: first received bit is channel NJOY-1 bit NBITS-1; last received bit is channel 0 bit 0 (MSB-first, highest channel first).
- Debounce, per channel in DONE:
  - If raw OUTW bits equal the previous frame's raw bits, a saturating counter increments; otherwise it resets to 1 and the previous raw value is updated.
  - When the counter >= DEBOUNCE, joy[c] takes the raw value.
  - DEBOUNCE=1: joy updates every frame.
- valid is high exactly one clock (the clock of the DONE ce tick). changed is high in the same clock iff the new joy differs from the old joy. Both are 0 at all other times.
- enable deasserted mid-frame: the frame completes including DONE/valid, then IDLE. Re-asserted in IDLE: LOAD starts on the next ce.
- ce=0: all state, outputs and timers hold. valid/changed never stretch beyond one clock.
- Bits NBITS-1..OUTW of each channel are shifted in and discarded.

Decomposition:
- Package joystick_pkg: FSM state enum (IDLE, LOAD, LOW, HIGH, DONE), helper function for counter width (clog2).
- Sub-module joystick_debounce: one per channel, generated NJOY times. Inputs: raw OUTW bits, update strobe. Outputs: stable value, change flag.
- The top module holds the FSM, phase timer, bit counter and FRAME-bit shift register.

Test Plan:
- Defaults, DEBOUNCE=1, chain model returning joyD=0 for channel 0 bit 0 only -> after first valid, joy=12'h001, changed=1. Frame period is 34 ce ticks; joyLd low exactly 1 tick per frame.
- Defaults, DEBOUNCE=2, channel 1 bit 2 pressed -> joy stays 0 after frame 1; joy=12'h100 with changed=1 after frame 2; frame 3 gives valid=1, changed=0.
- One-frame glitch (pressed in frame 2 only, DEBOUNCE=2) -> joy remains 0 throughout, changed never asserted.
- DIV=3, ce every 2nd clock -> joyCk high/low phases each 6 clocks, LOAD 6 clocks, sampled bits identical to the DIV=1 run.
- enable dropped at bit 5 of a frame -> frame completes, one valid pulse, then joyCk=0/joyLd=1 held. Re-enable -> LOAD on the next ce.
- reset_n pulsed low mid-frame (asynchronous, between clock edges) -> outputs 0 immediately; the next frame starts from LOAD with debounce counters cleared.
- NJOY=4, NBITS=12, OUTW=8 -> FRAME=48, joy width 32, channel mapping per bit order verified with a walking-zero pattern.

Source files
------------

// File: rtl/joystick_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// joystick_pkg : frame-sequencer state type and counter-width helper
// Revision 1.0
// ---------------------------------------------------------------------
package joystick_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    LOW  = 3'd2,
    HIGH = 3'd3,
    DONE = 3'd4
  } state_t;

  // Bits needed to hold a counter ranging over 0..n-1 (never less than 1).
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/joystick_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------
// joystick_debounce : frame-agreement filter for one joystick channel
// Revision 1.0
// ---------------------------------------------------------------------
module joystick_debounce
  import joystick_pkg::*;
#(
  parameter int OUTW     = 6,
  parameter int DEBOUNCE = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            update,
  input  logic [OUTW-1:0] raw,
  output logic [OUTW-1:0] stable,
  output logic            changed
);

  localparam int             c_CNT_W = cntWidth(DEBOUNCE + 1);
  localparam logic [c_CNT_W-1:0] c_SAT = c_CNT_W'(DEBOUNCE);

  logic [OUTW-1:0]    r_prev;
  logic [OUTW-1:0]    r_stable;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_changed;
  logic [OUTW-1:0]    w_nextStable;
  logic [c_CNT_W-1:0] w_nextCnt;

  always_comb begin
    w_nextCnt    = r_cnt;
    w_nextStable = r_stable;
    if (raw == r_prev) begin
      if (r_cnt != c_SAT) w_nextCnt = r_cnt + 1'b1;
    end else begin
      w_nextCnt = c_CNT_W'(1);
    end
    if (w_nextCnt >= c_SAT) w_nextStable = raw;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_stable  <= '0;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= update && (w_nextStable != r_stable);
      if (update) begin
        r_prev   <= raw;
        r_cnt    <= w_nextCnt;
        r_stable <= w_nextStable;
      end
    end
  end

  assign stable  = r_stable;
  assign changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/joystick_serial.sv
`default_nettype none
// ---------------------------------------------------------------------
// joystick_serial : 74165-chain joystick reader with per-channel debounce
// Revision 1.0
// ---------------------------------------------------------------------
module joystick_serial
  import joystick_pkg::*;
#(
  parameter int NJOY     = 2,
  parameter int NBITS    = 8,
  parameter int OUTW     = 6,
  parameter int DIV      = 1,
  parameter int DEBOUNCE = 2,
  parameter int INVERT   = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 enable,
  output logic [NJOY*OUTW-1:0] joy,
  output logic                 valid,
  output logic                 changed,
  output logic                 joyS,
  output logic                 joyCk,
  output logic                 joyLd,
  input  logic                 joyD
);

  localparam int c_FRAME = NJOY * NBITS;
  localparam int c_PH_W  = cntWidth(DIV);
  localparam int c_BIT_W = cntWidth(c_FRAME);
  localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_FRAME - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [c_PH_W-1:0]    r_phase;
  logic [c_BIT_W-1:0]   r_bitCnt;
  logic [c_FRAME-1:0]   r_shift;
  logic                 r_valid;
  logic [NJOY-1:0]      w_chg;
  logic                 w_phaseEnd;
  logic                 w_sampleBit;
  logic                 w_update;
  logic                 w_unusedShift;

  assign w_phaseEnd  = (r_phase == c_PH_LAST);
  assign w_sampleBit = (INVERT != 0) ? ~joyD : joyD;
  assign w_update    = ce && (r_state == DONE);

  always_comb begin
    w_nextState = r_state;
    joyLd       = 1'b1;
    joyCk       = 1'b0;
    case (r_state)
      IDLE: if (enable) w_nextState = LOAD;
      LOAD: begin
        joyLd = 1'b0;
        if (w_phaseEnd) w_nextState = LOW;
      end
      LOW:  if (w_phaseEnd) w_nextState = HIGH;
      HIGH: begin
        joyCk = 1'b1;
        if (w_phaseEnd) w_nextState = (r_bitCnt == c_BIT_LAST) ? DONE : LOW;
      end
      DONE:    w_nextState = enable ? LOAD : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_update;
      if (ce) begin
        r_state <= w_nextState;
        if (r_state inside {LOAD, LOW, HIGH})
          r_phase <= w_phaseEnd ? '0 : r_phase + 1'b1;
        else
          r_phase <= '0;
        // MSB-first shifting leaves channel c at [c*NBITS +: NBITS] once the frame ends.
        if (r_state == HIGH && w_phaseEnd) begin
          r_shift  <= {r_shift[c_FRAME-2:0], w_sampleBit};
          r_bitCnt <= (r_bitCnt == c_BIT_LAST) ? '0 : r_bitCnt + 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < NJOY; c++) begin : g_chan
    joystick_debounce #(
      .OUTW     (OUTW),
      .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
      .clock   (clock),
      .reset_n (reset_n),
      .update  (w_update),
      .raw     (r_shift[c*NBITS +: OUTW]),
      .stable  (joy[c*OUTW +: OUTW]),
      .changed (w_chg[c])
    );
  end

  // Upper bits of each channel are shifted through but never reported.
  assign w_unusedShift = ^r_shift;

  assign valid   = r_valid;
  assign changed = |w_chg;
  assign joyS    = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_joystick_serial.sv
`default_nettype none
// Bench for joystick_serial: default-parameter instance (A) and a wide,
// divided, ce-gated instance (B), each fed by a behavioural shift chain.
module tb_joystick_serial;

  localparam int A_FRAME = 16;
  localparam int B_FRAME = 48;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rstA_n, ceA, enA, joyDA;
  logic [11:0] joyA;
  logic        validA, changedA, joySA, joyCkA, joyLdA;

  logic        rstB_n, enB, joyDB;
  logic        ceB = 1'b0;
  logic [31:0] joyB;
  logic        validB, changedB, joySB, joyCkB, joyLdB;

  always @(negedge clock) ceB = ~ceB;

  joystick_serial #(.NJOY(2), .NBITS(8), .OUTW(6), .DIV(1), .DEBOUNCE(2), .INVERT(1)) dutA (
    .clock(clock), .reset_n(rstA_n), .ce(ceA), .enable(enA), .joy(joyA), .valid(validA),
    .changed(changedA), .joyS(joySA), .joyCk(joyCkA), .joyLd(joyLdA), .joyD(joyDA));

  joystick_serial #(.NJOY(4), .NBITS(12), .OUTW(8), .DIV(3), .DEBOUNCE(1), .INVERT(1)) dutB (
    .clock(clock), .reset_n(rstB_n), .ce(ceB), .enable(enB), .joy(joyB), .valid(validB),
    .changed(changedB), .joyS(joySB), .joyCk(joyCkB), .joyLd(joyLdB), .joyD(joyDB));

  // Chain model: 1 = pressed; bit k of the frame is presented during the k-th
  // high phase, first bit = highest channel MSB, buttons are active low.
  logic [15:0] pressA = '0;
  logic [47:0] pressB = '0;
  int posA = 0, posB = 0;

  always @(negedge joyLdA or negedge joyCkA) if (!joyLdA) posA = 0; else posA = posA + 1;
  always @(negedge joyLdB or negedge joyCkB) if (!joyLdB) posB = 0; else posB = posB + 1;

  assign joyDA = (posA < A_FRAME) ? ~pressA[A_FRAME-1-posA] : 1'b1;
  assign joyDB = (posB < B_FRAME) ? ~pressB[B_FRAME-1-posB] : 1'b1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitValid(input bit isB, input int budget, output int cyc,
                           output int ldLow, output int ckHigh);
    bit got   = 1'b0;
    int stray = 0;
    cyc = 0; ldLow = 0; ckHigh = 0;
    while (!got && cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (!(isB ? joyLdB : joyLdA)) ldLow++;
      if (isB ? joyCkB : joyCkA) ckHigh++;
      if (isB ? validB : validA) got = 1'b1;
      else if (isB ? changedB : changedA) stray++;
    end
    check(isB ? "validB within budget" : "validA within budget", got, 1);
    check(isB ? "changedB only with valid" : "changedA only with valid", stray, 0);
  endtask

  // Debounce reference for instance A (2 channels, 6 reported bits, 2 frames).
  logic [5:0] mPrev[2];
  logic [5:0] mJoy[2];
  int         mCnt[2];

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      mPrev[c] = '0; mJoy[c] = '0; mCnt[c] = 0;
    end
  endtask

  task automatic modelA(output logic [11:0] ej, output logic ec);
    logic [11:0] old;
    old = {mJoy[1], mJoy[0]};
    for (int c = 0; c < 2; c++) begin
      logic [5:0] raw;
      raw = pressA[c*8 +: 6];
      if (raw == mPrev[c]) mCnt[c] = (mCnt[c] < 2) ? mCnt[c] + 1 : 2;
      else begin
        mCnt[c]  = 1;
        mPrev[c] = raw;
      end
      if (mCnt[c] >= 2) mJoy[c] = raw;
    end
    ej = {mJoy[1], mJoy[0]};
    ec = (ej != old);
  endtask

  function automatic logic [31:0] gatherB(input logic [47:0] pr);
    logic [31:0] r = '0;
    for (int c = 0; c < 4; c++) r[c*8 +: 8] = pr[c*12 +: 8];
    return r;
  endfunction

  typedef struct {
    logic [15:0] press;
    logic [11:0] expJoy;
    logic        expChg;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int          cyc, ld, ck;
    logic [11:0] ej;
    logic        ec;
    logic [31:0] expB, prevB;
    bit          ok;
    logic [1:0]  cap;

    tbl[0] = '{16'h0400, 12'h000, 1'b0};  // ch1 bit2, first sighting
    tbl[1] = '{16'h0400, 12'h100, 1'b1};  // agreed twice
    tbl[2] = '{16'h0400, 12'h100, 1'b0};
    tbl[3] = '{16'h0000, 12'h100, 1'b0};  // release needs two frames too
    tbl[4] = '{16'h0000, 12'h000, 1'b1};
    tbl[5] = '{16'h0001, 12'h000, 1'b0};  // one-frame glitch
    tbl[6] = '{16'h0000, 12'h000, 1'b0};
    tbl[7] = '{16'h0000, 12'h000, 1'b0};
    tbl[8] = '{16'h00C0, 12'h000, 1'b0};  // unreported bits 7..6 of ch0
    tbl[9] = '{16'h8000, 12'h000, 1'b0};

    rstA_n = 1'b0; ceA = 1'b1; enA = 1'b0;
    rstB_n = 1'b0; enB = 1'b0;
    modelReset();

    repeat (3) @(negedge clock);
    check("A reset state", {joyA, validA, changedA, joyCkA, joyLdA, joySA}, {12'h000, 5'b00011});
    check("B reset state", {joyB, validB, changedB, joyCkB, joyLdB, joySB}, {32'h0, 5'b00011});
    rstA_n = 1'b1;
    repeat (5) @(negedge clock);
    check("A idle without enable", {joyLdA, joyCkA, validA}, 3'b100);

    pressA = tbl[0].press;
    enA    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      waitValid(1'b0, 200, cyc, ld, ck);
      modelA(ej, ec);
      check($sformatf("tbl[%0d] joy", i), joyA, tbl[i].expJoy);
      check($sformatf("tbl[%0d] changed", i), changedA, tbl[i].expChg);
      if (i > 0) begin
        check("A frame period", cyc, 34);
        check("A load ticks", ld, 1);
        check("A clock-high ticks", ck, 16);
      end
      if (i < 9) pressA = tbl[i+1].press;
    end

    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(2, 0) == 0) pressA = 16'($urandom);
      if (f == 5) begin
        repeat (8) @(negedge clock);
        cap = {joyCkA, joyLdA};
        ceA = 1'b0;
        ok  = 1'b1;
        repeat (20) begin
          @(negedge clock);
          if ({joyCkA, joyLdA} != cap || validA) ok = 1'b0;
        end
        ceA = 1'b1;
        check("ce low holds sequencer", ok, 1);
      end
      waitValid(1'b0, 200, cyc, ld, ck);
      modelA(ej, ec);
      check("random joy", joyA, ej);
      check("random changed", changedA, ec);
      if (f != 5) check("random frame period", cyc, 34);
    end

    // Drop enable around bit 5 of a frame.
    pressA = 16'h1B2C;
    repeat (10) @(negedge clock);
    enA = 1'b0;
    waitValid(1'b0, 100, cyc, ld, ck);
    modelA(ej, ec);
    check("stop-frame joy", joyA, ej);
    check("stop-frame changed", changedA, ec);
    ok = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (validA || joyCkA || !joyLdA) ok = 1'b0;
    end
    check("idle after enable drop", ok, 1);
    enA = 1'b1;
    @(negedge clock);
    check("load on next ce after re-enable", joyLdA, 0);
    waitValid(1'b0, 100, cyc, ld, ck);
    modelA(ej, ec);
    check("re-enabled joy", joyA, ej);
    check("re-enabled changed", changedA, ec);

    // Asynchronous reset between clock edges, mid-frame.
    repeat (9) @(negedge clock);
    #2 rstA_n = 1'b0;
    #1;
    check("async reset outputs", {joyA, validA, changedA, joyCkA, joyLdA}, {12'h000, 4'b0001});
    modelReset();
    @(negedge clock);
    rstA_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      waitValid(1'b0, 100, cyc, ld, ck);
      modelA(ej, ec);
      check("post-reset joy", joyA, ej);
      check("post-reset changed", changedA, ec);
    end
    enA = 1'b0;

    // Instance B: walking pressed bit (joyD low at one position) across 48 bits.
    @(negedge clock);
    rstB_n = 1'b1;
    pressB = 48'd1;
    prevB  = '0;
    enB    = 1'b1;
    for (int p = 0; p < B_FRAME; p++) begin
      waitValid(1'b1, 1500, cyc, ld, ck);
      expB = gatherB(pressB);
      check($sformatf("walk %0d joy", p), joyB, expB);
      check($sformatf("walk %0d changed", p), changedB, expB != prevB);
      if (p > 0) begin
        check("B frame period", cyc, 584);
        check("B load clocks", ld, 6);
        check("B clock-high clocks", ck, 288);
      end
      prevB = expB;
      if (p < B_FRAME - 1) pressB = 48'd1 << (p + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
